// File: rtl/decode_pkg.sv
// Shared definitions for the RV32 bundle decoder.
// Opcode encodings, instruction field bit offsets, exec class codes and
// the storage state encoding used by decode_bundle and decode_lane.
// Every opcode listed here ends in 2'b11. Any instruction whose low two bits
// are not 2'b11 therefore falls through to the unknown-opcode path.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam int RS2_LSB   = 20;
  localparam int RS1_LSB   = 15;
  localparam int RD_LSB    = 7;
  localparam int FUNC3_LSB = 12;
  localparam int FUNC7_LSB = 25;

  localparam logic [3:0] CLS_ILLEGAL = 4'd0;
  localparam logic [3:0] CLS_ALU_R   = 4'd1;
  localparam logic [3:0] CLS_ALU_I   = 4'd2;
  localparam logic [3:0] CLS_LOAD    = 4'd3;
  localparam logic [3:0] CLS_STORE   = 4'd4;
  localparam logic [3:0] CLS_BRANCH  = 4'd5;
  localparam logic [3:0] CLS_LUI     = 4'd6;
  localparam logic [3:0] CLS_AUIPC   = 4'd7;
  localparam logic [3:0] CLS_JAL     = 4'd8;
  localparam logic [3:0] CLS_JALR    = 4'd9;
  localparam logic [3:0] CLS_MULDIV  = 4'd10;
  localparam logic [3:0] CLS_SYSTEM  = 4'd11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } store_state_e;

endpackage

// File: rtl/decode_lane.sv
// Combinational decoder for one RV32 instruction.
// Optional feature macro: DECODE_MULDIV_EN. When it is defined, R-type with
// func7=0000001 decodes as MULDIV. When it is not defined, that encoding is illegal.
// Ports:
//   inst        instruction word
//   lane_valid  lane carries an instruction. When it is 0, every output is 0.
//   rs1/rs2/rd  register indices. The index is 0 when the format has no such register.
//   func3       func3 field. It is 0 for U/J formats.
//   func7       func7 field. It is non-zero only for R-type.
//   imm         sign-extended immediate. It is 0 for R-type.
//   cls         exec class code
//   illegal     unsupported opcode/func combination. The lane's class is then 0 and its fields are 0.
module decode_lane
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RF_WIDTH    = 5,
  parameter int EXEC_WIDTH  = 4,
  parameter int FUNC3_WIDTH = 3,
  parameter int FUNC7_WIDTH = 7
) (
  input  logic [DATA_WIDTH-1:0]  inst,
  input  logic                   lane_valid,
  output logic [RF_WIDTH-1:0]    rs1,
  output logic [RF_WIDTH-1:0]    rs2,
  output logic [RF_WIDTH-1:0]    rd,
  output logic [FUNC3_WIDTH-1:0] func3,
  output logic [FUNC7_WIDTH-1:0] func7,
  output logic [DATA_WIDTH-1:0]  imm,
  output logic [EXEC_WIDTH-1:0]  cls,
  output logic                   illegal
);

  logic [6:0]             opcode;
  logic [RF_WIDTH-1:0]    f_rs1, f_rs2, f_rd;
  logic [FUNC3_WIDTH-1:0] f_func3;
  logic [FUNC7_WIDTH-1:0] f_func7;
  logic [DATA_WIDTH-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = inst[6:0];
  assign f_rs1   = inst[RS1_LSB +: RF_WIDTH];
  assign f_rs2   = inst[RS2_LSB +: RF_WIDTH];
  assign f_rd    = inst[RD_LSB +: RF_WIDTH];
  assign f_func3 = inst[FUNC3_LSB +: FUNC3_WIDTH];
  assign f_func7 = inst[FUNC7_LSB +: FUNC7_WIDTH];

  assign imm_i = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    rs1     = '0;
    rs2     = '0;
    rd      = '0;
    func3   = '0;
    func7   = '0;
    imm     = '0;
    cls     = EXEC_WIDTH'(CLS_ILLEGAL);
    illegal = 1'b0;
    if (lane_valid) begin
      case (opcode)
        OP_R: begin
          rs1   = f_rs1;
          rs2   = f_rs2;
          rd    = f_rd;
          func3 = f_func3;
          func7 = f_func7;
          // 0x20 is only meaningful for SUB (000) and SRA (101).
          if (f_func7 == 7'h00 || (f_func7 == 7'h20 && (f_func3 == 3'b000 || f_func3 == 3'b101)))
            cls = EXEC_WIDTH'(CLS_ALU_R);
`ifdef DECODE_MULDIV_EN
          else if (f_func7 == 7'h01)
            cls = EXEC_WIDTH'(CLS_MULDIV);
`endif
          else
            illegal = 1'b1;
        end
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
          rs1   = f_rs1;
          rd    = f_rd;
          func3 = f_func3;
          imm   = imm_i;
          case (opcode)
            OP_IMM:  cls = EXEC_WIDTH'(CLS_ALU_I);
            OP_LOAD: cls = EXEC_WIDTH'(CLS_LOAD);
            OP_JALR: cls = EXEC_WIDTH'(CLS_JALR);
            default: cls = EXEC_WIDTH'(CLS_SYSTEM);
          endcase
        end
        OP_STORE, OP_BRANCH: begin
          rs1   = f_rs1;
          rs2   = f_rs2;
          func3 = f_func3;
          imm   = (opcode == OP_STORE) ? imm_s : imm_b;
          cls   = (opcode == OP_STORE) ? EXEC_WIDTH'(CLS_STORE) : EXEC_WIDTH'(CLS_BRANCH);
        end
        OP_LUI, OP_AUIPC: begin
          rd  = f_rd;
          imm = imm_u;
          cls = (opcode == OP_LUI) ? EXEC_WIDTH'(CLS_LUI) : EXEC_WIDTH'(CLS_AUIPC);
        end
        OP_JAL: begin
          rd  = f_rd;
          imm = imm_j;
          cls = EXEC_WIDTH'(CLS_JAL);
        end
        default: illegal = 1'b1;
      endcase
      // Illegal lanes carry no operands downstream, only the flag.
      if (illegal) begin
        rs1   = '0;
        rs2   = '0;
        rd    = '0;
        func3 = '0;
        func7 = '0;
        imm   = '0;
        cls   = EXEC_WIDTH'(CLS_ILLEGAL);
      end
    end
  end

endmodule

// File: rtl/decode_bundle.sv
// Registered multi-lane RV32 decode stage with a two-entry skid buffer.
// Optional feature macro: DECODE_MULDIV_EN. It enables MULDIV decode inside decode_lane.
//
// Handshake: a bundle moves on every edge where valid and ready are both high,
// on its side of the stage. Input side: DEC_dataValid & DEC_ready. Output side:
// out_valid & out_ready. A producer holds valid and data until the transfer
// happens. Ready does not depend on valid.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   flush                   drop both stored bundles and any bundle presented this cycle
//   DEC_data/laneValid/dataValid, DEC_ready   input bundle handshake
//   out_valid/out_ready     output bundle handshake
//   out_laneValid, out_rs1/rs2/rd, out_func3/func7, out_imm, out_class, out_illegal
//                           decoded per-lane fields of the oldest stored bundle
//   dbg_state               storage FSM state (0 EMPTY, 1 ONE, 2 TWO)
module decode_bundle
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IPC         = 4,
  parameter int RF_WIDTH    = 5,
  parameter int EXEC_WIDTH  = 4,
  parameter int FUNC3_WIDTH = 3,
  parameter int FUNC7_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [IPC*DATA_WIDTH-1:0]  DEC_data,
  input  logic [IPC-1:0]             DEC_laneValid,
  input  logic                       DEC_dataValid,
  output logic                       DEC_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IPC-1:0]             out_laneValid,
  output logic [IPC*RF_WIDTH-1:0]    out_rs1,
  output logic [IPC*RF_WIDTH-1:0]    out_rs2,
  output logic [IPC*RF_WIDTH-1:0]    out_rd,
  output logic [IPC*FUNC3_WIDTH-1:0] out_func3,
  output logic [IPC*FUNC7_WIDTH-1:0] out_func7,
  output logic [IPC*DATA_WIDTH-1:0]  out_imm,
  output logic [IPC*EXEC_WIDTH-1:0]  out_class,
  output logic [IPC-1:0]             out_illegal,
  output logic [1:0]                 dbg_state
);

  localparam int LANE_W  = 1 + 3*RF_WIDTH + FUNC3_WIDTH + FUNC7_WIDTH + DATA_WIDTH + EXEC_WIDTH + 1;
  localparam int ENTRY_W = IPC * LANE_W;

  store_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] dec_entry, main_q, skid_q;
  logic               accept, drain;
  logic               take_new_main, take_skid_main, take_new_skid;

  // Decode happens before the registers, so both entries hold decoded fields.
  for (genvar g = 0; g < IPC; g++) begin : g_lane
    logic [RF_WIDTH-1:0]    rs1_w, rs2_w, rd_w;
    logic [FUNC3_WIDTH-1:0] func3_w;
    logic [FUNC7_WIDTH-1:0] func7_w;
    logic [DATA_WIDTH-1:0]  imm_w;
    logic [EXEC_WIDTH-1:0]  cls_w;
    logic                   ill_w;

    decode_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .RF_WIDTH   (RF_WIDTH),
      .EXEC_WIDTH (EXEC_WIDTH),
      .FUNC3_WIDTH(FUNC3_WIDTH),
      .FUNC7_WIDTH(FUNC7_WIDTH)
    ) u_lane (
      .inst      (DEC_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .lane_valid(DEC_laneValid[g]),
      .rs1       (rs1_w),
      .rs2       (rs2_w),
      .rd        (rd_w),
      .func3     (func3_w),
      .func7     (func7_w),
      .imm       (imm_w),
      .cls       (cls_w),
      .illegal   (ill_w)
    );

    assign dec_entry[g*LANE_W +: LANE_W] =
      {DEC_laneValid[g], rs1_w, rs2_w, rd_w, func3_w, func7_w, imm_w, cls_w, ill_w};

    assign {out_laneValid[g], out_rs1[g*RF_WIDTH +: RF_WIDTH], out_rs2[g*RF_WIDTH +: RF_WIDTH],
            out_rd[g*RF_WIDTH +: RF_WIDTH], out_func3[g*FUNC3_WIDTH +: FUNC3_WIDTH],
            out_func7[g*FUNC7_WIDTH +: FUNC7_WIDTH], out_imm[g*DATA_WIDTH +: DATA_WIDTH],
            out_class[g*EXEC_WIDTH +: EXEC_WIDTH], out_illegal[g]} = main_q[g*LANE_W +: LANE_W];
  end

  // Ready depends only on the state register, so the upstream sees no comb path.
  assign DEC_ready = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = DEC_dataValid & DEC_ready;
  assign drain     = out_valid & out_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d        = state_q;
    take_new_main  = 1'b0;
    take_skid_main = 1'b0;
    take_new_skid  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d       = ST_ONE;
          take_new_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          take_new_main = 1'b1;
        end else if (accept) begin
          state_d       = ST_TWO;
          take_new_skid = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d        = ST_ONE;
          take_skid_main = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides accept and drain in every state.
    if (flush) begin
      state_d        = ST_EMPTY;
      take_new_main  = 1'b0;
      take_skid_main = 1'b0;
      take_new_skid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take_new_main)       main_q <= dec_entry;
      else if (take_skid_main) main_q <= skid_q;
      if (take_new_skid)       skid_q <= dec_entry;
    end
  end

endmodule

// File: tb/tb_decode_bundle.sv
// Directed bench for decode_bundle. It uses hand-computed decode vectors.
// A small in-order scoreboard tracks lane-0 immediates across backpressure.
module tb_decode_bundle;
  localparam int DW = 32, IPC = 4, RF = 5, EX = 4, F3 = 3, F7 = 7;

  logic clk = 1'b0;
  logic rst, flush;
  logic [IPC*DW-1:0] dec_data;
  logic [IPC-1:0]    dec_lane_valid;
  logic              dec_data_valid, dec_ready;
  logic              out_valid, out_ready;
  logic [IPC-1:0]    out_lane_valid, out_illegal;
  logic [IPC*RF-1:0] out_rs1, out_rs2, out_rd;
  logic [IPC*F3-1:0] out_func3;
  logic [IPC*F7-1:0] out_func7;
  logic [IPC*DW-1:0] out_imm;
  logic [IPC*EX-1:0] out_class;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  decode_bundle u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .DEC_data(dec_data), .DEC_laneValid(dec_lane_valid), .DEC_dataValid(dec_data_valid),
    .DEC_ready(dec_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_laneValid(out_lane_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm), .out_class(out_class),
    .out_illegal(out_illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] l_imm(input int l);  return out_imm[l*DW +: DW];   endfunction
  function automatic logic [3:0]  l_cls(input int l);  return out_class[l*EX +: EX]; endfunction
  function automatic logic [4:0]  l_rs1(input int l);  return out_rs1[l*RF +: RF];   endfunction
  function automatic logic [4:0]  l_rs2(input int l);  return out_rs2[l*RF +: RF];   endfunction
  function automatic logic [4:0]  l_rd(input int l);   return out_rd[l*RF +: RF];    endfunction
  function automatic logic [2:0]  l_f3(input int l);   return out_func3[l*F3 +: F3]; endfunction

  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | 32'h0000_0093;  // addi x1, x0, k
  endfunction

  // driver tasks
  task automatic put_bundle(input logic [IPC*DW-1:0] d, input logic [IPC-1:0] lv);
    dec_data       = d;
    dec_lane_valid = lv;
    dec_data_valid = 1'b1;
  endtask

  task automatic drive_idle();
    dec_data       = '0;
    dec_lane_valid = '0;
    dec_data_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : main
    int sent, drained, ghosts;
    logic [31:0] e_imm[4];
    logic [3:0]  e_cls[4];

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    // A bundle presented during reset must be ignored.
    put_bundle({96'b0, 32'h0050_0093}, 4'b0001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_ready", dec_ready, 1);
    check_val("rst_lane_valid", out_lane_valid, 0);
    check_val("rst_imm", out_imm, 0);
    check_val("rst_class", out_class, 0);
    check_val("rst_state", dbg_state, 0);
    rst = 1'b0;
    drive_idle();
    tick();
    check_val("rst_ignored_bundle", out_valid, 0);

    // add x3,x1,x2 on lane 0 only
    out_ready = 1'b1;
    put_bundle({96'b0, 32'h0020_81B3}, 4'b0001);
    tick();
    drive_idle();
    check_val("add_valid", out_valid, 1);
    check_val("add_rs1", l_rs1(0), 1);
    check_val("add_rs2", l_rs2(0), 2);
    check_val("add_rd", l_rd(0), 3);
    check_val("add_class", l_cls(0), 1);
    check_val("add_imm", l_imm(0), 0);
    check_val("add_illegal", out_illegal, 0);
    check_val("add_lane_valid", out_lane_valid, 4'b0001);
    check_val("add_idle_lanes_imm", out_imm[127:32], 0);
    check_val("add_idle_lanes_rd", out_rd[19:5], 0);

    // I / S / B / U formats across four lanes
    put_bundle({32'h0000_12B7, 32'hFE00_0EE3, 32'h0020_A423, 32'h0050_0093}, 4'b1111);
    tick();
    drive_idle();
    e_imm = '{32'd5, 32'd8, 32'hFFFF_FFFC, 32'h0000_1000};
    e_cls = '{4'd2, 4'd4, 4'd5, 4'd6};
    for (int l = 0; l < 4; l++) begin
      check_val($sformatf("fmt_imm_l%0d", l), l_imm(l), e_imm[l]);
      check_val($sformatf("fmt_cls_l%0d", l), l_cls(l), e_cls[l]);
    end
    check_val("fmt_lane_valid", out_lane_valid, 4'b1111);
    check_val("fmt_addi_rd", l_rd(0), 1);
    check_val("fmt_sw_rs1", l_rs1(1), 1);
    check_val("fmt_sw_rs2", l_rs2(1), 2);
    check_val("fmt_sw_f3", l_f3(1), 2);
    check_val("fmt_sw_rd", l_rd(1), 0);
    check_val("fmt_lui_rd", l_rd(3), 5);
    check_val("fmt_lui_f3", l_f3(3), 0);
    check_val("fmt_illegal", out_illegal, 0);

    // mul, bad opcode, sub, and an illegal word on an invalid lane
    put_bundle({32'h4000_1033, 32'h4000_0033, 32'h0000_007F, 32'h0220_81B3}, 4'b0111);
    tick();
    drive_idle();
`ifdef DECODE_MULDIV_EN
    check_val("mul_class", l_cls(0), 10);
    check_val("mul_illegal", out_illegal[0], 0);
`else
    check_val("mul_class", l_cls(0), 0);
    check_val("mul_illegal", out_illegal[0], 1);
`endif
    check_val("badop_illegal", out_illegal[1], 1);
    check_val("badop_class", l_cls(1), 0);
    check_val("sub_class", l_cls(2), 1);
    check_val("sub_illegal", out_illegal[2], 0);
    check_val("off_lane_illegal", out_illegal[3], 0);
    check_val("off_lane_valid", out_lane_valid[3], 0);

    // func7=0x20 allowed with 101, rejected with 001
    put_bundle({64'b0, 32'h4000_5033, 32'h4000_1033}, 4'b0011);
    tick();
    drive_idle();
    check_val("f7_001_illegal", out_illegal[0], 1);
    check_val("f7_001_rd", l_rd(0), 0);
    check_val("sra_class", l_cls(1), 1);
    check_val("sra_illegal", out_illegal[1], 0);

    // full throughput with out_ready=1
    for (int k = 0; k < 4; k++) begin
      put_bundle({96'b0, addi(20 + k)}, 4'b0001);
      tick();
      check_val($sformatf("stream_imm_%0d", k), l_imm(0), 32'(20 + k));
      check_val($sformatf("stream_ready_%0d", k), dec_ready, 1);
    end
    drive_idle();
    tick();
    check_val("stream_drained", out_valid, 0);

    // backpressure: fill both entries, third bundle must wait
    out_ready = 1'b0;
    sent = 0;
    drained = 0;
    put_bundle({96'b0, addi(30)}, 4'b0001);
    check_val("bp_ready_0", dec_ready, 1);
    exp_q.push_back(32'd30); sent++;
    tick();
    put_bundle({96'b0, addi(31)}, 4'b0001);
    check_val("bp_ready_1", dec_ready, 1);
    exp_q.push_back(32'd31); sent++;
    tick();
    put_bundle({96'b0, addi(32)}, 4'b0001);
    check_val("bp_ready_low", dec_ready, 0);
    check_val("bp_state_two", dbg_state, 2);
    check_val("bp_hold_imm", l_imm(0), 30);
    tick();
    check_val("bp_stable_imm", l_imm(0), 30);
    check_val("bp_stable_ready", dec_ready, 0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check_val("bp_extra", 1, 0);
        else check_val("bp_order", l_imm(0), exp_q.pop_front());
        drained++;
      end
      if (dec_data_valid && dec_ready) begin
        exp_q.push_back(32'(30 + sent));
        sent++;
      end
      tick();
      if (sent == 3) drive_idle();
      if (sent == 3 && exp_q.size() == 0 && !out_valid) break;
    end
    check_val("bp_sent", sent, 3);
    check_val("bp_drained", drained, 3);
    check_val("bp_queue_empty", exp_q.size(), 0);

    // flush with both entries full and a bundle on the input
    out_ready = 1'b0;
    put_bundle({96'b0, addi(100)}, 4'b0001);
    tick();
    put_bundle({96'b0, addi(101)}, 4'b0001);
    tick();
    check_val("fl_state_two", dbg_state, 2);
    put_bundle({96'b0, addi(102)}, 4'b0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_idle();
    check_val("fl_out_valid", out_valid, 0);
    check_val("fl_ready", dec_ready, 1);
    check_val("fl_state", dbg_state, 0);
    out_ready = 1'b1;
    ghosts = 0;
    repeat (3) begin
      tick();
      if (out_valid) ghosts++;
    end
    check_val("fl_no_ghost", ghosts, 0);
    put_bundle({96'b0, addi(7)}, 4'b0001);
    tick();
    drive_idle();
    check_val("fl_after_valid", out_valid, 1);
    check_val("fl_after_imm", l_imm(0), 7);
    tick();

    // reset pulse while holding one entry
    out_ready = 1'b0;
    put_bundle({96'b0, addi(55)}, 4'b0001);
    tick();
    drive_idle();
    check_val("pr_state_one", dbg_state, 1);
    rst = 1'b1;
    put_bundle({96'b0, addi(56)}, 4'b0001);
    tick();
    rst = 1'b0;
    drive_idle();
    check_val("pr_out_valid", out_valid, 0);
    check_val("pr_ready", dec_ready, 1);
    check_val("pr_imm", out_imm, 0);
    check_val("pr_lane_valid", out_lane_valid, 0);
    out_ready = 1'b1;
    put_bundle({96'b0, 32'h0020_81B3}, 4'b0001);
    tick();
    drive_idle();
    check_val("pr_add_valid", out_valid, 1);
    check_val("pr_add_rs1", l_rs1(0), 1);
    check_val("pr_add_rs2", l_rs2(0), 2);
    check_val("pr_add_rd", l_rd(0), 3);
    check_val("pr_add_class", l_cls(0), 1);
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
